dm_ext: RTL
===========

Name: dm_ext

Overview:
Parametrised data memory that succeeds the word-only DM.
- Adds byte/half/word loads and stores, with sign or zero extension on loads.
- Detects misaligned and out-of-range accesses.
- Uses a valid/ready request port and a fixed-latency response port.
- Clears its array with a post-reset sweep, one word per cycle.
- Sits in the MEM stage of the CPU, or behind a stall-capable memory controller.

Parameters:
DEPTH_WORDS, 3072, number of 32-bit words in the array
BASE_ADDR, 32'h0000_0000, byte address of word 0
RSP_LAT, 1, cycles from request accept to response (must be >= 1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  request can be accepted this cycle
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_pc  input  32  PC of the requesting instruction, used for trace only
rsp_valid  output  1  one-cycle pulse, response present
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  access fault, valid while rsp_valid is high

Behaviour:
- Accept: an accept occurs when req_valid && req_ready at a rising edge.
- FSM states: CLEAR, IDLE, BUSY.
- Reset cycle:
  - state <= CLEAR and clear_idx <= 0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- CLEAR:
  - Each cycle, RAM[clear_idx] <= 0 and clear_idx increments.
  - After writing index DEPTH_WORDS-1, go to IDLE.
  - Sweep takes exactly DEPTH_WORDS cycles after reset deasserts.
  - req_ready=0 throughout.
- IDLE:
  - req_ready=1.
  - On accept, go to BUSY and load lat_cnt with RSP_LAT-1.
- BUSY:
  - req_ready=0.
  - Decrement lat_cnt each cycle.
  - When lat_cnt==0, drive rsp_valid=1 for exactly that cycle and return to IDLE.
- Timing and ordering:
  - Response appears exactly RSP_LAT cycles after the accept edge.
  - A new accept is possible in the cycle after rsp_valid, so at most one request is outstanding.
- Index and lane decode:
  - off = req_addr - BASE_ADDR, computed as 32-bit unsigned.
  - idx = off[31:2]; lane = off[1:0].
- Error conditions (any one sets err=1):
  - req_size==11.
  - size 01 with off[0]!=0.
  - size 10 with off[1:0]!=0.
  - idx >= DEPTH_WORDS, including wrap below BASE_ADDR.
- Store without error:
  - Written at the accept edge; only the addressed byte lanes change.
  - Byte: lane L gets wdata[7:0].
  - Half: lanes {L+1,L} get wdata[15:0].
  - Word: the full word is written.
- Load without error:
  - RAM is read at the accept edge.
  - The lane is extracted, extended per req_unsigned, and registered until the response.
- Error response:
  - No RAM write occurs.
  - rsp_err=1 and rsp_rdata=0.
- Output hold: rsp_rdata and rsp_err hold their last values when rsp_valid=0; they are cleared only by reset.
- Reset mid-operation: reset has priority in any state. It discards any pending response (no rsp_valid afterwards) and restarts CLEAR from index 0.
- Inputs are ignored when req_ready=0.

Optional Feature:
Macro DM_TRACE_EN.
- When defined, each successful store prints one line at the accept edge: "@%h: *%h <= %h".
  - Fields are req_pc, then the word-aligned byte address (BASE_ADDR + idx*4), then the full merged 32-bit word after the write.
- Failed stores print nothing.
- When not defined, no $display is compiled and behaviour is otherwise identical.

Test Plan:
- Reset, then count cycles -> req_ready rises exactly 3072 cycles after reset falls; a load of word 0x0 returns 0x00000000 with err=0.
- Store word 0x11223344 @0x10, then sb 0xAA @0x11, then lw @0x10 -> 0x1122AA44. lb @0x11 -> 0xFFFFFFAA; lbu @0x11 -> 0x000000AA.
- sh 0x8001 @0x22, then lh @0x22 -> 0xFFFF8001 and lhu @0x22 -> 0x00008001. lw @0x20 shows 0x8001 in [31:16] and 0 in [15:0].
- Faults:
  - lw @0x13 -> err=1, rdata=0.
  - sh @0x21 -> err=1 and the word at 0x20 is unchanged.
  - lw @0x3000 (idx 3072) -> err=1.
- RSP_LAT=3: store accepted at cycle t -> rsp_valid only at t+3 and req_ready low during t+1..t+3. Assert reset at t+2 -> no rsp_valid, and CLEAR restarts.
- With DM_TRACE_EN: sb 0xAA @0x11 with pc 0x3000, over 0x11223344 -> prints "@00003000: *00000010 <= 1122aa44".

Source files
------------

// File: rtl/dm_ext.sv
// dm_ext -- byte/half/word data memory with valid/ready request port and
// fixed-latency response port.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req_valid/ready   request handshake (accept = valid && ready at clk edge)
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      loads zero-extend when 1, sign-extend when 0
//   req_addr          byte address
//   req_wdata         store data, right-aligned
//   req_pc            PC of the requester (trace only)
//   rsp_valid         one-cycle response pulse, RSP_LAT cycles after accept
//   rsp_rdata         extended load data (0 for stores and faults)
//   rsp_err           misaligned / illegal-size / out-of-range fault
//
// After reset the array is zeroed by a sweep of DEPTH_WORDS cycles during
// which req_ready stays low.
//
// Optional: define DM_TRACE_EN to print one line per successful store:
//   "@<pc>: *<word address> <= <merged word>"
module dm_ext #(
  parameter int          DEPTH_WORDS = 3072,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          RSP_LAT     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          LW      = (RSP_LAT > 1) ? $clog2(RSP_LAT) : 1;
  localparam logic [31:0] DEPTH_U = DEPTH_WORDS;

  typedef enum logic [1:0] {CLEAR, IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [IW-1:0] clear_idx;
  logic [LW-1:0] lat_cnt;

  // Result captured at accept, published on rsp_valid, then held.
  logic [31:0] pend_rdata, last_rdata;
  logic        pend_err, last_err;

  logic          accept;
  logic [31:0]   off;
  logic [1:0]    lane;
  logic [IW-1:0] idx;
  logic          err;
  logic [31:0]   rd_word, wr_word, ld_data;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;

  // ---------------------------------------------------------------- decode
  always_comb begin
    off  = req_addr - BASE_ADDR;   // wraps below BASE_ADDR -> huge index
    lane = off[1:0];
    idx  = off[IW+1:2];
    err  = (req_size == 2'b11)
         || (req_size == 2'b01 && off[0])
         || (req_size == 2'b10 && off[1:0] != 2'b00)
         || ({2'b00, off[31:2]} >= DEPTH_U);
  end

  assign rd_word = mem[idx];

  // Load extraction and store merge both work on the addressed word.
  always_comb begin
    sel_byte = rd_word[{lane, 3'b000} +: 8];
    sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_size)
      2'b00:   ld_data = req_unsigned ? {24'h0, sel_byte}
                                      : {{24{sel_byte[7]}}, sel_byte};
      2'b01:   ld_data = req_unsigned ? {16'h0, sel_half}
                                      : {{16{sel_half[15]}}, sel_half};
      default: ld_data = rd_word;
    endcase

    wr_word = rd_word;
    case (req_size)
      2'b00: wr_word[{lane, 3'b000} +: 8] = req_wdata[7:0];
      2'b01: begin
        if (lane[1]) wr_word[31:16] = req_wdata[15:0];
        else         wr_word[15:0]  = req_wdata[15:0];
      end
      2'b10:   wr_word = req_wdata;
      default: wr_word = rd_word;
    endcase
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clear_idx == IW'(DEPTH_WORDS - 1)) state_nxt = IDLE;
      IDLE:    if (req_valid)                         state_nxt = BUSY;
      BUSY:    if (lat_cnt == '0)                     state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  // Outputs are forced quiet while reset is asserted.
  always_comb begin
    req_ready = (state == IDLE) && !reset;
    rsp_valid = (state == BUSY) && (lat_cnt == '0) && !reset;
    if (reset) begin
      rsp_rdata = 32'h0;
      rsp_err   = 1'b0;
    end else if (rsp_valid) begin
      rsp_rdata = pend_rdata;
      rsp_err   = pend_err;
    end else begin
      rsp_rdata = last_rdata;
      rsp_err   = last_err;
    end
  end

  assign accept = req_valid && req_ready;

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      clear_idx  <= '0;
      lat_cnt    <= '0;
      pend_rdata <= 32'h0;
      pend_err   <= 1'b0;
      last_rdata <= 32'h0;
      last_err   <= 1'b0;
    end else begin
      if (state == CLEAR) clear_idx <= clear_idx + 1'b1;
      if (accept) begin
        lat_cnt    <= LW'(RSP_LAT - 1);
        pend_rdata <= (req_we || err) ? 32'h0 : ld_data;
        pend_err   <= err;
      end else if (state == BUSY && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (rsp_valid) begin
        last_rdata <= pend_rdata;
        last_err   <= pend_err;
      end
    end
  end

  // Array has no reset: the CLEAR sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR)                 mem[clear_idx] <= 32'h0;
      else if (accept && req_we && !err)  mem[idx]       <= wr_word;
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (accept && req_we && !err)
      $display("@%h: *%h <= %h", req_pc, BASE_ADDR + {off[31:2], 2'b00}, wr_word);
  end
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

endmodule
